// File: rtl/ccff_cfg_pkg.sv
// ----------------------------------------------------------------------------
// ccff_cfg_pkg
//   Shared definitions for the CCFF chain reader and writer paths.
//   Provides:
//     ccff_state_e : FSM state encoding {IDLE, SHIFT, FLUSH, DONE}
//     cnt_w()      : width of a bit counter that must hold 0..CHAIN_LEN
//     idx_w()      : width of a word bit index that must hold 0..WORD_W
// ----------------------------------------------------------------------------
package ccff_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } ccff_state_e;

   function automatic int cnt_w(input int chain_len);
      return $clog2(chain_len + 1);
   endfunction

   function automatic int idx_w(input int word_w);
      return $clog2(word_w + 1);
   endfunction

endpackage

// File: rtl/ccff_chain_reader_if.sv
// ----------------------------------------------------------------------------
// ccff_chain_reader_if
//   Word stream from the chain reader to its consumer.
//   Handshake: word_data is a valid word whenever word_valid=1; the word is
//   consumed at a rising clk edge where word_valid & word_ready are both 1.
//   While word_valid=1 and word_ready=0 the producer holds word_data stable
//   and keeps word_valid high.
//   Signals:
//     word_data  [WORD_W] packed word, bit0 = earliest chain bit (master -> slave)
//     word_valid          word_data holds an unaccepted word  (master -> slave)
//     word_ready          consumer accepts this edge          (slave -> master)
// ----------------------------------------------------------------------------
interface ccff_chain_reader_if #(
   parameter int WORD_W = 8
);
   logic [WORD_W-1:0] word_data;
   logic              word_valid;
   logic              word_ready;

   modport master (output word_data, output word_valid, input word_ready);
   modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/ccff_word_packer.sv
// ----------------------------------------------------------------------------
// ccff_word_packer
//   Packs a serial bit stream LSB-first into WORD_W-bit words. An assembly
//   register (asm) collects bits; a one-entry holding register presents the
//   completed word on a valid/ready output.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     clr_i          synchronous clear of all state (abort)
//     bit_in_i       serial data bit
//     bit_we_i       write bit_in_i into asm this edge
//     flush_i        with bit_we_i: this is the final bit, close the word
//     word_ready_i   consumer ready
//     word_data_o    holding register contents
//     word_valid_o   holding register occupied
//     asm_full_o     assembly register holds a finished word
//     transfer_o     asm moves into hold at this edge (combinational)
// ----------------------------------------------------------------------------
module ccff_word_packer
   import ccff_cfg_pkg::*;
#(
   parameter int WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              bit_in_i,
   input  logic              bit_we_i,
   input  logic              flush_i,
   input  logic              word_ready_i,
   output logic [WORD_W-1:0] word_data_o,
   output logic              word_valid_o,
   output logic              asm_full_o,
   output logic              transfer_o
);

   localparam int IDX_W = idx_w(WORD_W);

   logic [WORD_W-1:0] asm_q, asm_d;
   logic [WORD_W-1:0] hold_q, hold_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              full_q, full_d;
   logic              valid_q, valid_d;
   logic              transfer;

   // asm moves to hold when hold is empty or being drained this same edge.
   assign transfer = full_q & (~valid_q | word_ready_i);

   always_comb begin
      asm_d   = asm_q;
      idx_d   = idx_q;
      full_d  = full_q;
      hold_d  = hold_q;
      valid_d = valid_q;
      if (valid_q & word_ready_i) begin
         valid_d = 1'b0;
      end
      // asm is zeroed on transfer so a partial final word is zero-padded.
      if (transfer) begin
         hold_d  = asm_q;
         valid_d = 1'b1;
         asm_d   = '0;
         idx_d   = '0;
         full_d  = 1'b0;
      end
      // A bit arriving on the transfer edge lands in the freshly emptied asm.
      if (bit_we_i) begin
         for (int i = 0; i < WORD_W; i++) begin
            if (idx_d == IDX_W'(i)) begin
               asm_d[i] = bit_in_i;
            end
         end
         if ((idx_d == IDX_W'(WORD_W - 1)) || flush_i) begin
            full_d = 1'b1;
         end
         idx_d = idx_d + 1'b1;
      end
      if (clr_i) begin
         asm_d   = '0;
         idx_d   = '0;
         full_d  = 1'b0;
         hold_d  = '0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_q   <= '0;
         idx_q   <= '0;
         full_q  <= 1'b0;
         hold_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         asm_q   <= asm_d;
         idx_q   <= idx_d;
         full_q  <= full_d;
         hold_q  <= hold_d;
         valid_q <= valid_d;
      end
   end

   assign word_data_o  = hold_q;
   assign word_valid_o = valid_q;
   assign asm_full_o   = full_q;
   assign transfer_o   = transfer;

endmodule

// File: rtl/ccff_chain_reader.sv
// ----------------------------------------------------------------------------
// ccff_chain_reader
//   Non-destructive readback of a CHAIN_LEN-bit configuration flip-flop chain.
//   Shifts the chain tail out, optionally recirculating it into the head, and
//   streams the bits LSB-first as WORD_W-bit words.
//   Ports:
//     clk, rst_n    clock (chain shifts on the same edge), async active-low reset
//     start         1-cycle readback request, honoured in IDLE only
//     abort         synchronous cancel, overrides everything
//     shift_en_o    chain shift enable for this edge
//     ccff_head_o   bit into the chain head
//     ccff_tail_i   chain tail bit shifted out this edge
//     word_if       word stream (master side)
//     busy          high in SHIFT and FLUSH
//     done          1-cycle pulse after the last word is accepted
//     state_o       current FSM state, for observation
// ----------------------------------------------------------------------------
module ccff_chain_reader
   import ccff_cfg_pkg::*;
#(
   parameter int CHAIN_LEN = 64,
   parameter int WORD_W    = 8,
   parameter int RECIRC    = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       abort,
   output logic                       shift_en_o,
   output logic                       ccff_head_o,
   input  logic                       ccff_tail_i,
   ccff_chain_reader_if.master        word_if,
   output logic                       busy,
   output logic                       done,
   output ccff_state_e                state_o
);

   localparam int                CNT_W    = cnt_w(CHAIN_LEN);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CHAIN_LEN - 1);

   ccff_state_e      state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             busy_q, done_q;
   logic             asm_full, transfer, last_bit, shift_en, drain_ok;
   logic [WORD_W-1:0] pk_data;
   logic             pk_valid;

   assign last_bit = (bit_cnt_q == LAST_CNT);

   // Combinational from word_ready (through transfer) and from abort: the
   // chain keeps moving on the edge a finished word leaves asm, and an abort
   // freezes the chain on the very edge it is sampled.
   assign shift_en = (state_q == SHIFT) & ~abort & (~asm_full | transfer);

   // Nothing left in asm, and hold is empty or drained on this edge.
   assign drain_ok = ~asm_full & (~pk_valid | word_if.word_ready);

   ccff_word_packer #(
      .WORD_W (WORD_W)
   ) u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_i        (abort),
      .bit_in_i     (ccff_tail_i),
      .bit_we_i     (shift_en),
      .flush_i      (last_bit),
      .word_ready_i (word_if.word_ready),
      .word_data_o  (pk_data),
      .word_valid_o (pk_valid),
      .asm_full_o   (asm_full),
      .transfer_o   (transfer)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      if (abort) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d   = SHIFT;
                  bit_cnt_d = '0;
               end
            end
            SHIFT: begin
               if (shift_en) begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (last_bit) begin
                     state_d = FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (drain_ok) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               state_d   = IDLE;
               bit_cnt_d = '0;
            end
            default: begin
               state_d   = IDLE;
               bit_cnt_d = '0;
            end
         endcase
      end
   end

   // busy/done are registered alongside the state they decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         busy_q    <= (state_d == SHIFT) || (state_d == FLUSH);
         done_q    <= (state_d == DONE);
      end
   end

   assign shift_en_o         = shift_en;
   assign ccff_head_o        = (RECIRC != 0) ? (shift_en & ccff_tail_i) : 1'b0;
   assign word_if.word_data  = pk_data;
   assign word_if.word_valid = pk_valid;
   assign busy               = busy_q;
   assign done               = done_q;
   assign state_o            = state_q;

endmodule

// File: tb/tb_ccff_chain_reader.sv
module tb_ccff_chain_reader;
   import ccff_cfg_pkg::*;

   localparam int W  = 8;
   localparam int LA = 64;
   localparam int LB = 12;
   localparam int TMO = 3000;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT A: 64-bit chain, recirculating ----------------
   logic        start_a = 1'b0, abort_a = 1'b0;
   logic        sh_a, head_a, tail_a, busy_a, done_a;
   ccff_state_e st_a;
   ccff_chain_reader_if #(.WORD_W(W)) if_a ();

   ccff_chain_reader #(.CHAIN_LEN(LA), .WORD_W(W), .RECIRC(1)) u_dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start_a),
      .abort       (abort_a),
      .shift_en_o  (sh_a),
      .ccff_head_o (head_a),
      .ccff_tail_i (tail_a),
      .word_if     (if_a),
      .busy        (busy_a),
      .done        (done_a),
      .state_o     (st_a)
   );

   // ---------------- DUT B: 12-bit chain, no recirculation ----------------
   logic        start_b = 1'b0, abort_b = 1'b0;
   logic        sh_b, head_b, tail_b, busy_b, done_b;
   ccff_state_e st_b;
   ccff_chain_reader_if #(.WORD_W(W)) if_b ();
   assign if_b.word_ready = 1'b1;

   ccff_chain_reader #(.CHAIN_LEN(LB), .WORD_W(W), .RECIRC(0)) u_dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start_b),
      .abort       (abort_b),
      .shift_en_o  (sh_b),
      .ccff_head_o (head_b),
      .ccff_tail_i (tail_b),
      .word_if     (if_b),
      .busy        (busy_b),
      .done        (done_b),
      .state_o     (st_b)
   );

   // ---------------- counters ----------------
   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- chain models (the environment) ----------------
   // chain[0] is the tail; a shift moves every bit one place toward the tail
   // and takes the head bit into the top position.
   logic [LA-1:0] chain_a = '0, load_val_a = '0;
   logic [LB-1:0] chain_b = '0, load_val_b = '0;
   logic          load_a = 1'b0, load_b = 1'b0;
   logic          pend_a = 1'b0, pend_head_a = 1'b0, pend_b = 1'b0, pend_head_b = 1'b0;
   int            nshift_a = 0, nshift_b = 0;

   assign tail_a = chain_a[0];
   assign tail_b = chain_b[0];

   always @(posedge clk) begin
      if (load_a) chain_a <= load_val_a;
      else if (pend_a) begin
         chain_a  <= {pend_head_a, chain_a[LA-1:1]};
         nshift_a <= nshift_a + 1;
      end
      if (load_b) chain_b <= load_val_b;
      else if (pend_b) begin
         chain_b  <= {pend_head_b, chain_b[LB-1:1]};
         nshift_b <= nshift_b + 1;
      end
   end

   // ---------------- ready driver for A ----------------
   logic hold_lo_a = 1'b0, rand_rdy = 1'b0;
   always begin
      if_a.word_ready = hold_lo_a ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      @(posedge clk);
      #1;
   end

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];          // expected words of the current A run
   logic [W-1:0] acc_a[$], acc_b[$];
   int           run_a = 0, seen_a = 0, rd_a = 0;
   int           dones_a = 0, dones_b = 0;
   logic         stall_a = 1'b0;
   logic [W-1:0] stall_data_a = '0;

   // Words expected from a chain holding c: consecutive W-bit slices starting
   // at the tail, final slice zero-padded.
   task automatic fill_exp(input logic [LA-1:0] c);
      exp_q.delete();
      for (int k = 0; k < (LA + W - 1) / W; k++) begin
         logic [W-1:0] w;
         w = '0;
         for (int j = 0; j < W; j++) if (k * W + j < LA) w[j] = c[k * W + j];
         exp_q.push_back(w);
      end
      run_a++;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         pend_a  = 1'b0;
         pend_b  = 1'b0;
         stall_a = 1'b0;
      end else begin
         if (run_a != seen_a) begin
            seen_a = run_a;
            rd_a   = 0;
         end
         if (if_a.word_valid && if_a.word_ready) begin
            acc_a.push_back(if_a.word_data);
            if (rd_a < exp_q.size()) check("a_word", 64'(if_a.word_data), 64'(exp_q[rd_a]));
            else check("a_extra_word", 64'(1), 64'(0));
            rd_a++;
         end
         if (stall_a && if_a.word_valid) check("a_data_stable", 64'(if_a.word_data), 64'(stall_data_a));
         stall_a      = if_a.word_valid && !if_a.word_ready;
         stall_data_a = if_a.word_data;
         if (sh_a) check("a_head_recirc", 64'(head_a), 64'(tail_a));
         if (done_a) dones_a++;
         pend_a      = sh_a;
         pend_head_a = head_a;

         if (if_b.word_valid && if_b.word_ready) acc_b.push_back(if_b.word_data);
         if (sh_b) check("b_head_zero", 64'(head_b), 64'(0));
         if (done_b) dones_b++;
         pend_b      = sh_b;
         pend_head_b = head_b;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic preload_a(input logic [LA-1:0] v);
      load_val_a = v;
      load_a     = 1'b1;
      cyc(1);
      load_a     = 1'b0;
      cyc(1);
   endtask

   task automatic pulse_start_a();
      start_a = 1'b1;
      cyc(1);
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(input int d0);
      int c;
      c = 0;
      while (dones_a == d0 && c < TMO) begin
         cyc(1);
         c++;
      end
      check("a_done_timeout", 64'(c < TMO), 64'(1));
      cyc(3);
   endtask

   // Full readback of A from its current contents, with end-of-run checks.
   task automatic full_run_a(input string tag, input bit double_start);
      logic [LA-1:0] snap;
      int n0, d0, w0;
      snap = chain_a;
      n0 = nshift_a; d0 = dones_a; w0 = acc_a.size();
      fill_exp(snap);
      pulse_start_a();
      check({tag, "_busy"}, 64'(busy_a), 64'(1));
      if (double_start) begin
         cyc(10);
         pulse_start_a();
      end
      wait_done_a(d0);
      check({tag, "_shifts"}, 64'(nshift_a - n0), 64'(LA));
      check({tag, "_dones"}, 64'(dones_a - d0), 64'(1));
      check({tag, "_nwords"}, 64'(acc_a.size() - w0), 64'(LA / W));
      check({tag, "_consumed"}, 64'(rd_a), 64'(LA / W));
      check({tag, "_chain_kept"}, 64'(chain_a), 64'(snap));
      check({tag, "_idle"}, 64'(st_a), 64'(IDLE));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [LA-1:0] p, rot;
      int n0, d0, w0, c;

      // reset state
      #1;
      check("rst_shift_en", 64'(sh_a), 64'(0));
      check("rst_valid", 64'(if_a.word_valid), 64'(0));
      check("rst_data", 64'(if_a.word_data), 64'(0));
      check("rst_busy", 64'(busy_a), 64'(0));
      check("rst_done", 64'(done_a), 64'(0));
      check("rst_state", 64'(st_a), 64'(IDLE));
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(2);

      // Partial final word on the 12-bit chain: 0xFF then zero-padded 0x0F.
      load_val_b = 12'hFFF;
      load_b = 1'b1;
      cyc(1);
      load_b = 1'b0;
      start_b = 1'b1;
      cyc(1);
      start_b = 1'b0;
      c = 0;
      while (dones_b == 0 && c < TMO) begin
         cyc(1);
         c++;
      end
      check("b_done_timeout", 64'(c < TMO), 64'(1));
      cyc(2);
      check("b_nwords", 64'(acc_b.size()), 64'(2));
      if (acc_b.size() >= 2) begin
         check("b_word0", 64'(acc_b[0]), 64'(8'hFF));
         check("b_word1", 64'(acc_b[1]), 64'(8'h0F));
      end
      check("b_shifts", 64'(nshift_b), 64'(LB));
      check("b_dones", 64'(dones_b), 64'(1));
      check("b_chain_flushed", 64'(chain_b), 64'(0));

      // Known leading pattern, ready always high; also the recirculation check.
      p = {$urandom, $urandom};
      p[15:0] = 16'h3CA5;
      preload_a(p);
      w0 = acc_a.size();
      full_run_a("t1", 1'b0);
      if (acc_a.size() >= w0 + 2) begin
         check("t1_word0", 64'(acc_a[w0]), 64'(8'hA5));
         check("t1_word1", 64'(acc_a[w0 + 1]), 64'(8'h3C));
      end

      // Back-pressure: first word held unaccepted long enough to stall the chain.
      p = {$urandom, $urandom};
      p[15:0] = 16'h3CA5;
      preload_a(p);
      hold_lo_a = 1'b1;
      cyc(1);
      n0 = nshift_a; d0 = dones_a; w0 = acc_a.size();
      fill_exp(p);
      pulse_start_a();
      c = 0;
      while (!if_a.word_valid && c < 200) begin
         cyc(1);
         c++;
      end
      check("t2_valid_timeout", 64'(c < 200), 64'(1));
      cyc(12);
      check("t2_stalled", 64'(sh_a), 64'(0));
      check("t2_hold_word", 64'(if_a.word_data), 64'(8'hA5));
      check("t2_shifts_at_stall", 64'(nshift_a - n0), 64'(2 * W));
      hold_lo_a = 1'b0;
      wait_done_a(d0);
      check("t2_shifts", 64'(nshift_a - n0), 64'(LA));
      check("t2_chain_kept", 64'(chain_a), 64'(p));
      if (acc_a.size() >= w0 + 2) begin
         check("t2_word0", 64'(acc_a[w0]), 64'(8'hA5));
         check("t2_word1", 64'(acc_a[w0 + 1]), 64'(8'h3C));
      end

      // Random contents, random ready, and an ignored start while busy.
      rand_rdy = 1'b1;
      for (int r = 0; r < 3; r++) begin
         preload_a({$urandom, $urandom});
         full_run_a("t4", 1'b1);
      end
      rand_rdy = 1'b0;
      cyc(2);

      // Abort after five bits.
      p = {$urandom, $urandom};
      preload_a(p);
      n0 = nshift_a; d0 = dones_a;
      fill_exp(p);
      pulse_start_a();
      c = 0;
      while ((nshift_a - n0) < 5 && c < 200) begin
         cyc(1);
         c++;
      end
      check("t5_abort_point", 64'(nshift_a - n0), 64'(5));
      abort_a = 1'b1;
      cyc(1);
      abort_a = 1'b0;
      check("t5_idle", 64'(st_a), 64'(IDLE));
      check("t5_valid", 64'(if_a.word_valid), 64'(0));
      check("t5_busy", 64'(busy_a), 64'(0));
      cyc(4);
      check("t5_no_done", 64'(dones_a - d0), 64'(0));
      rot = (p >> 5) | (p << (LA - 5));
      check("t5_rotated", 64'(chain_a), 64'(rot));
      full_run_a("t5_rerun", 1'b0);

      // Asynchronous reset mid-SHIFT while a word is waiting.
      preload_a({$urandom, $urandom});
      hold_lo_a = 1'b1;
      cyc(1);
      fill_exp(chain_a);
      pulse_start_a();
      c = 0;
      while (!if_a.word_valid && c < 200) begin
         cyc(1);
         c++;
      end
      check("t6_valid_before_rst", 64'(if_a.word_valid), 64'(1));
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_shift_en", 64'(sh_a), 64'(0));
      check("t6_valid", 64'(if_a.word_valid), 64'(0));
      check("t6_data", 64'(if_a.word_data), 64'(0));
      check("t6_busy", 64'(busy_a), 64'(0));
      check("t6_done", 64'(done_a), 64'(0));
      check("t6_state", 64'(st_a), 64'(IDLE));
      hold_lo_a = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(2);
      check("t6_after_state", 64'(st_a), 64'(IDLE));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
